// File: rtl/odom_pkg.sv
// Shared odometry definitions: word format defaults, Q15 saturation limits,
// wheel count, the estimator FSM state type and the quadrature phase helper.
package odom_pkg;

  localparam int ODOM_DATAWIDTH_N  = 32;
  localparam int ODOM_FRACTIONAL_Q = 15;
  localparam int NUM_WHEELS        = 4;

  // Limits of a signed Q(32,15) word.
  localparam logic signed [31:0] Q15_SAT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] Q15_SAT_MIN = 32'sh8000_0000;

  // Cycles after reset release during which the decoders only track inputs.
  localparam logic [1:0] PRIME_CYCLES = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_LOAD = 2'd2
  } wve_state_e;

  // Maps a Gray-coded {A,B} pair onto a linear phase 0..3 so that a forward
  // step (00->01->11->10->00) is always +1 modulo 4.
  function automatic logic [1:0] quad_phase(input logic [1:0] ab);
    quad_phase = {ab[1], ab[1] ^ ab[0]};
  endfunction

endpackage

// File: rtl/wheel_velocity_estimator_quad_decoder.sv
// One x4 quadrature channel: input synchronizer, priming, transition decode,
// saturating signed edge counter with snapshot/clear, and sticky error flag.
module quad_decoder
  import odom_pkg::*;
#(
  parameter int COUNT_WIDTH = 16,
  parameter bit INVERT      = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enc_a,
  input  logic                          enc_b,
  input  logic                          snap,
  output logic signed [COUNT_WIDTH-1:0] snap_count,
  output logic                          err
);

  localparam logic signed [COUNT_WIDTH-1:0] CNT_MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
  localparam logic signed [COUNT_WIDTH-1:0] CNT_MIN = -CNT_MAX;

  logic [1:0]                   sync1_q, sync1_d;
  logic [1:0]                   sync2_q, sync2_d;
  logic [1:0]                   prev_q,  prev_d;
  logic [1:0]                   prime_q, prime_d;
  logic signed [COUNT_WIDTH-1:0] count_q, count_d;
  logic signed [COUNT_WIDTH-1:0] snap_q,  snap_d;
  logic                         err_q,   err_d;

  logic [1:0]                   delta_s;
  logic signed [1:0]            raw_step_s;
  logic signed [1:0]            step_s;
  logic                         illegal_s;
  logic signed [COUNT_WIDTH-1:0] count_inc_s;

  // Next-state logic: synchronize, decode the phase change, update the counter.
  always_comb begin
    sync1_d    = {enc_a, enc_b};
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    prime_d    = prime_q;
    delta_s    = quad_phase(sync2_q) - quad_phase(prev_q);
    raw_step_s = 2'sd0;
    illegal_s  = 1'b0;

    if (prime_q < PRIME_CYCLES) begin
      // Synchronizer still filling: let prev follow without counting.
      prime_d = prime_q + 2'd1;
    end else begin
      prime_d = prime_q;
      case (delta_s)
        2'd1:    raw_step_s = 2'sd1;
        2'd3:    raw_step_s = -2'sd1;
        2'd2:    illegal_s  = 1'b1;
        default: raw_step_s = 2'sd0;
      endcase
    end

    if (INVERT) begin
      step_s = -raw_step_s;
    end else begin
      step_s = raw_step_s;
    end

    if (step_s == 2'sd1) begin
      if (count_q != CNT_MAX) begin
        count_inc_s = count_q + COUNT_WIDTH'(1);
      end else begin
        count_inc_s = count_q;
      end
    end else if (step_s == -2'sd1) begin
      if (count_q != CNT_MIN) begin
        count_inc_s = count_q - COUNT_WIDTH'(1);
      end else begin
        count_inc_s = count_q;
      end
    end else begin
      count_inc_s = count_q;
    end

    // The edge decoded in the snapshot cycle still belongs to the old window.
    if (snap) begin
      snap_d  = count_inc_s;
      count_d = {COUNT_WIDTH{1'b0}};
    end else begin
      snap_d  = snap_q;
      count_d = count_inc_s;
    end

    err_d = err_q | illegal_s;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      prev_q  <= 2'b00;
      prime_q <= 2'd0;
      count_q <= {COUNT_WIDTH{1'b0}};
      snap_q  <= {COUNT_WIDTH{1'b0}};
      err_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      prime_q <= prime_d;
      count_q <= count_d;
      snap_q  <= snap_d;
      err_q   <= err_d;
    end
  end

  assign snap_count = snap_q;
  assign err        = err_q;

endmodule

// File: rtl/wheel_velocity_estimator.sv
// Four-wheel velocity front end: per-wheel quadrature counting over a fixed
// window, then one shared multiplier converts counts to rad/s in Q(32,15).
module wheel_velocity_estimator
  import odom_pkg::*;
#(
  parameter int           DATAWIDTH_N   = ODOM_DATAWIDTH_N,
  parameter int           FRACTIONAL_Q  = ODOM_FRACTIONAL_Q,
  parameter int           SAMPLE_CYCLES = 500000,
  parameter int           COUNT_WIDTH   = 16,
  parameter int           SCALE_K       = 13762,
  parameter logic [3:0]   DIR_INVERT    = 4'b0000
) (
  input  logic                   WHEEL_VELOCITY_CLOCK_50,
  input  logic                   WHEEL_VELOCITY_Reset_InHigh,
  input  logic [3:0]             WHEEL_VELOCITY_ENC_A_InBus,
  input  logic [3:0]             WHEEL_VELOCITY_ENC_B_InBus,
  output logic [DATAWIDTH_N-1:0] WHEEL_VELOCITY_W1_OutBus,
  output logic [DATAWIDTH_N-1:0] WHEEL_VELOCITY_W2_OutBus,
  output logic [DATAWIDTH_N-1:0] WHEEL_VELOCITY_W3_OutBus,
  output logic [DATAWIDTH_N-1:0] WHEEL_VELOCITY_W4_OutBus,
  output logic                   WHEEL_VELOCITY_VALID_Out,
  output logic [3:0]             WHEEL_VELOCITY_ERR_OutBus
);

  // Product wide enough for count x K (K < 2^17) and for the output limits.
  localparam int PROD_W = (COUNT_WIDTH + 18 > DATAWIDTH_N + 1) ? COUNT_WIDTH + 18
                                                               : DATAWIDTH_N + 1;
  localparam int WIN_W  = $clog2(SAMPLE_CYCLES);
  localparam int IDX_W  = $clog2(NUM_WHEELS);

  localparam logic [WIN_W-1:0]         WIN_LAST = WIN_W'(SAMPLE_CYCLES - 1);
  localparam logic signed [PROD_W-1:0] SCALE_S  = PROD_W'(SCALE_K);
  localparam logic signed [PROD_W-1:0] SAT_MAX  = PROD_W'(Q15_SAT_MAX);
  localparam logic signed [PROD_W-1:0] SAT_MIN  = PROD_W'(Q15_SAT_MIN);

  if (SAMPLE_CYCLES < 8 || DATAWIDTH_N != ODOM_DATAWIDTH_N ||
      FRACTIONAL_Q != ODOM_FRACTIONAL_Q || SCALE_K >= 131072 || SCALE_K < 0) begin : g_bad_params
    $error("wheel_velocity_estimator: unsupported parameter set");
  end

  logic                           clk;
  logic                           rst;
  logic [WIN_W-1:0]               win_q, win_d;
  logic                           snap_s;
  logic signed [COUNT_WIDTH-1:0]  snap_cnt_s [NUM_WHEELS];
  logic [3:0]                     err_s;

  wve_state_e                     state_q;
  logic [IDX_W-1:0]               idx_q;
  logic signed [DATAWIDTH_N-1:0]  staging_q [NUM_WHEELS];
  logic [DATAWIDTH_N-1:0]         w_q [NUM_WHEELS];
  logic                           valid_q;

  logic signed [PROD_W-1:0]       mul_a_s;
  logic signed [PROD_W-1:0]       prod_s;
  logic signed [DATAWIDTH_N-1:0]  mul_sat_s;

  assign clk = WHEEL_VELOCITY_CLOCK_50;
  assign rst = WHEEL_VELOCITY_Reset_InHigh;

  // Window counter next state; the last count of a window is the snapshot cycle.
  always_comb begin
    if (win_q == WIN_LAST) begin
      win_d  = {WIN_W{1'b0}};
      snap_s = 1'b1;
    end else begin
      win_d  = win_q + WIN_W'(1);
      snap_s = 1'b0;
    end
  end

  // Window counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q <= {WIN_W{1'b0}};
    end else begin
      win_q <= win_d;
    end
  end

  for (genvar i = 0; i < NUM_WHEELS; i++) begin : g_dec
    quad_decoder #(
      .COUNT_WIDTH (COUNT_WIDTH),
      .INVERT      (DIR_INVERT[i])
    ) u_dec (
      .clk        (clk),
      .rst        (rst),
      .enc_a      (WHEEL_VELOCITY_ENC_A_InBus[i]),
      .enc_b      (WHEEL_VELOCITY_ENC_B_InBus[i]),
      .snap       (snap_s),
      .snap_count (snap_cnt_s[i]),
      .err        (err_s[i])
    );
  end

  // Shared multiplier: count is an integer and K is Q15, so the product is
  // already Q15; only saturation to the output word is needed.
  always_comb begin
    mul_a_s = PROD_W'(snap_cnt_s[idx_q]);
    prod_s  = mul_a_s * SCALE_S;
    if (prod_s > SAT_MAX) begin
      mul_sat_s = Q15_SAT_MAX;
    end else if (prod_s < SAT_MIN) begin
      mul_sat_s = Q15_SAT_MIN;
    end else begin
      mul_sat_s = prod_s[DATAWIDTH_N-1:0];
    end
  end

  // Conversion FSM: four multiply cycles, then all outputs update together.
  // Outputs and VALID are loaded on the MUL->LOAD edge so they are visible
  // during the LOAD cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= {IDX_W{1'b0}};
      valid_q <= 1'b0;
      for (int i = 0; i < NUM_WHEELS; i++) begin
        staging_q[i] <= {DATAWIDTH_N{1'b0}};
        w_q[i]       <= {DATAWIDTH_N{1'b0}};
      end
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          idx_q <= {IDX_W{1'b0}};
          if (snap_s) begin
            state_q <= ST_MUL;
          end
        end
        ST_MUL: begin
          staging_q[idx_q] <= mul_sat_s;
          if (idx_q == IDX_W'(NUM_WHEELS - 1)) begin
            for (int i = 0; i < NUM_WHEELS - 1; i++) begin
              w_q[i] <= staging_q[i];
            end
            w_q[NUM_WHEELS-1] <= mul_sat_s;
            valid_q           <= 1'b1;
            state_q           <= ST_LOAD;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_LOAD: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign WHEEL_VELOCITY_W1_OutBus  = w_q[0];
  assign WHEEL_VELOCITY_W2_OutBus  = w_q[1];
  assign WHEEL_VELOCITY_W3_OutBus  = w_q[2];
  assign WHEEL_VELOCITY_W4_OutBus  = w_q[3];
  assign WHEEL_VELOCITY_VALID_Out  = valid_q;
  assign WHEEL_VELOCITY_ERR_OutBus = err_s;

endmodule
